// File: rtl/rf_writeback_if.sv
// rtl/rf_writeback_if.sv - Writeback bundle between pipeline, LSU, register file and bypass
//
// Purpose: groups every non-clock signal of rf_writeback into one bundle.
// Ports (as seen by the writeback block, modport slave):
//   alu_valid_i/alu_rd_i/alu_wd_i    in   ALU result, one cycle, no backpressure
//   lsu_valid_i/lsu_rd_i/lsu_wd_i    in   load result offered
//   lsu_ready_o                      out  load result accepted when valid & ready
//   issue_i/issue_rd_i               in   load issued, mark destination pending
//   regwrite_o/rd_o/wd_o             out  registered register-file write port
//   busy_o                           out  pending-write scoreboard
//   stall_o                          out  upstream must not present an ALU result
//   rs1_i/rs2_i                      in   bypass lookup registers
//   fwd_a_o/fwd_b_o, *_hit_o         out  bypass data and hit flags
// The master modport is the mirror image, used by whatever drives the block.
interface rf_writeback_if;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_wd_i;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_wd_i;
  logic        lsu_ready_o;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic        regwrite_o;
  logic [4:0]  rd_o;
  logic [31:0] wd_o;
  logic [31:0] busy_o;
  logic        stall_o;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [31:0] fwd_a_o;
  logic [31:0] fwd_b_o;
  logic        fwd_a_hit_o;
  logic        fwd_b_hit_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_wd_i,
    input  lsu_valid_i, lsu_rd_i, lsu_wd_i,
    output lsu_ready_o,
    input  issue_i, issue_rd_i,
    output regwrite_o, rd_o, wd_o, busy_o, stall_o,
    input  rs1_i, rs2_i,
    output fwd_a_o, fwd_b_o, fwd_a_hit_o, fwd_b_hit_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_wd_i,
    output lsu_valid_i, lsu_rd_i, lsu_wd_i,
    input  lsu_ready_o,
    output issue_i, issue_rd_i,
    input  regwrite_o, rd_o, wd_o, busy_o, stall_o,
    output rs1_i, rs2_i,
    input  fwd_a_o, fwd_b_o, fwd_a_hit_o, fwd_b_hit_o
  );
endinterface

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - Register-file writeback arbiter with load buffer, scoreboard and bypass
//
// Purpose: merges single-cycle ALU results and buffered load results onto one
// registered register-file write port. The ALU normally wins; a starve counter
// forces a one-cycle DRAIN (stall_o high) so buffered loads cannot be held off
// forever. A 32-bit scoreboard tracks registers with loads in flight.
// Optional feature macro: RF_WB_BYPASS_EN enables the rs1/rs2 bypass compare;
// without it the bypass outputs are tied to zero.
// Ports:
//   clk_i     in   clock, rising edge
//   reset_ni  in   asynchronous active-low reset
//   wb        rf_writeback_if.slave (ALU/LSU inputs, write port, scoreboard, bypass)
module rf_writeback #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk_i,
  input logic           reset_ni,
  rf_writeback_if.slave wb
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {NORMAL, DRAIN} state_t;

  logic [4:0]       buf_rd_q [FIFO_DEPTH];
  logic [31:0]      buf_wd_q [FIFO_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       starve_q, starve_d;
  state_t           state_q, state_d;
  logic             stall_q;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      wd_q, wd_d;
  logic [31:0]      busy_q, busy_d;
  logic             buf_empty, lsu_ready, push, pop, alu_win;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign buf_empty = (count_q == '0);
  assign lsu_ready = (count_q < CNT_W'(FIFO_DEPTH));
  // Loads to x0 are acknowledged but never stored.
  assign push      = wb.lsu_valid_i && lsu_ready && (wb.lsu_rd_i != 5'd0);
  // An ALU result presented during DRAIN is dropped.
  assign alu_win   = (state_q == NORMAL) && wb.alu_valid_i && (wb.alu_rd_i != 5'd0);
  assign pop       = !buf_empty && ((state_q == DRAIN) || !alu_win);

  always_comb begin
    head_d = pop  ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    regwrite_d = 1'b0;
    rd_d       = '0;
    wd_d       = '0;
    if (pop) begin
      regwrite_d = 1'b1;
      rd_d       = buf_rd_q[head_q];
      wd_d       = buf_wd_q[head_q];
    end else if (alu_win) begin
      regwrite_d = 1'b1;
      rd_d       = wb.alu_rd_i;
      wd_d       = wb.alu_wd_i;
    end
  end

  // Starvation only accrues while the ALU is actually holding off a waiting load.
  always_comb begin
    state_d  = NORMAL;
    starve_d = '0;
    if (alu_win && !buf_empty) begin
      if (int'(starve_q) + 1 >= STARVE_LIMIT) state_d = DRAIN;
      else starve_d = starve_q + 3'd1;
    end
  end

  // Set after clear so a same-cycle issue to the retiring register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (regwrite_d) busy_d[rd_d] = 1'b0;
    if (wb.issue_i && (wb.issue_rd_i != 5'd0)) busy_d[wb.issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= NORMAL;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      stall_q    <= (state_d == DRAIN);
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
    end
  end

  // Payload storage needs no reset: validity is carried by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_rd_q[tail_q] <= wb.lsu_rd_i;
      buf_wd_q[tail_q] <= wb.lsu_wd_i;
    end
  end

  assign wb.lsu_ready_o = lsu_ready;
  assign wb.regwrite_o  = regwrite_q;
  assign wb.rd_o        = rd_q;
  assign wb.wd_o        = wd_q;
  assign wb.busy_o      = busy_q;
  assign wb.stall_o     = stall_q;

`ifdef RF_WB_BYPASS_EN
  logic hit_a, hit_b;
  assign hit_a          = regwrite_q && (rd_q == wb.rs1_i) && (wb.rs1_i != 5'd0);
  assign hit_b          = regwrite_q && (rd_q == wb.rs2_i) && (wb.rs2_i != 5'd0);
  assign wb.fwd_a_hit_o = hit_a;
  assign wb.fwd_b_hit_o = hit_b;
  assign wb.fwd_a_o     = hit_a ? wd_q : '0;
  assign wb.fwd_b_o     = hit_b ? wd_q : '0;
`else
  logic unused_rs;
  assign unused_rs      = ^{wb.rs1_i, wb.rs2_i};
  assign wb.fwd_a_hit_o = 1'b0;
  assign wb.fwd_b_hit_o = 1'b0;
  assign wb.fwd_a_o     = '0;
  assign wb.fwd_b_o     = '0;
`endif
endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - Self-checking bench for rf_writeback
module tb_rf_writeback;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] awd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lwd;
    logic        wr1;
    logic [4:0]  rd1;
    logic [31:0] wd1;
    logic        wr2;
    logic [4:0]  rd2;
    logic [31:0] wd2;
  } vec_t;

  logic clk_i    = 1'b0;
  logic reset_ni = 1'b1;
  int   n_tests  = 0;
  int   n_fail   = 0;

  // Reference model: loads waiting in a queue, plus the expected outputs.
  ent_t        mq[$];
  int          m_cnt;
  bit          m_drain;
  bit          m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic [31:0] m_busy;
  bit          s_ready;

  vec_t vecs[6];

  rf_writeback_if bus();

  rf_writeback #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .wb      (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                       input logic iss, input logic [4:0] ird);
    bus.alu_valid_i = av;  bus.alu_rd_i = ard;  bus.alu_wd_i = awd;
    bus.lsu_valid_i = lv;  bus.lsu_rd_i = lrd;  bus.lsu_wd_i = lwd;
    bus.issue_i     = iss; bus.issue_rd_i = ird;
  endtask

  task automatic check_outputs();
    bit ha, hb;
    ha = BYP && m_wr && (m_rd == bus.rs1_i) && (bus.rs1_i != 5'd0);
    hb = BYP && m_wr && (m_rd == bus.rs2_i) && (bus.rs2_i != 5'd0);
    check("regwrite", 32'(bus.regwrite_o), 32'(m_wr));
    if (m_wr) begin
      check("rd", 32'(bus.rd_o), 32'(m_rd));
      check("wd", bus.wd_o, m_wd);
    end
    check("busy", bus.busy_o, m_busy);
    check("stall", 32'(bus.stall_o), 32'(m_drain));
    check("fwd_a_hit", 32'(bus.fwd_a_hit_o), 32'(ha));
    check("fwd_b_hit", 32'(bus.fwd_b_hit_o), 32'(hb));
    if (!BYP || ha) check("fwd_a", bus.fwd_a_o, ha ? m_wd : 32'h0);
    if (!BYP || hb) check("fwd_b", bus.fwd_b_o, hb ? m_wd : 32'h0);
  endtask

  // One clock: apply inputs, check ready, advance the model, check outputs.
  task automatic do_cycle(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                          input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                          input logic iss, input logic [4:0] ird);
    bit   rdy;
    ent_t e;
    drive(av, ard, awd, lv, lrd, lwd, iss, ird);
    #1;
    rdy     = (mq.size() < DEPTH);
    s_ready = bus.lsu_ready_o;
    check("lsu_ready", 32'(bus.lsu_ready_o), 32'(rdy));
    m_wr = 1'b0; m_rd = '0; m_wd = '0;
    if (m_drain) begin
      if (mq.size() > 0) begin
        e = mq.pop_front(); m_wr = 1'b1; m_rd = e.rd; m_wd = e.wd;
      end
      m_drain = 1'b0;
      m_cnt   = 0;
    end else if (av && ard != 5'd0) begin
      m_wr = 1'b1; m_rd = ard; m_wd = awd;
      if (mq.size() > 0) begin
        m_cnt++;
        if (m_cnt == LIMIT) begin
          m_drain = 1'b1;
          m_cnt   = 0;
        end
      end else m_cnt = 0;
    end else begin
      m_cnt = 0;
      if (mq.size() > 0) begin
        e = mq.pop_front(); m_wr = 1'b1; m_rd = e.rd; m_wd = e.wd;
      end
    end
    if (lv && rdy && lrd != 5'd0) mq.push_back('{rd: lrd, wd: lwd});
    if (m_wr) m_busy[m_rd] = 1'b0;
    if (iss && ird != 5'd0) m_busy[ird] = 1'b1;
    @(posedge clk_i);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset with live inputs, checks the async clear and the held state.
  task automatic do_reset();
    drive(1, 5'd5, 32'h1, 1, 5'd6, 32'h2, 1, 5'd8);
    reset_ni = 1'b0;
    #1;
    check("rst_async_regwrite", 32'(bus.regwrite_o), 32'h0);
    check("rst_async_busy", bus.busy_o, 32'h0);
    mq.delete();
    m_cnt = 0; m_drain = 0; m_wr = 0; m_rd = '0; m_wd = '0; m_busy = '0;
    @(posedge clk_i);
    #1;
    check("rst_regwrite", 32'(bus.regwrite_o), 32'h0);
    check("rst_rd", 32'(bus.rd_o), 32'h0);
    check("rst_wd", bus.wd_o, 32'h0);
    check("rst_busy", bus.busy_o, 32'h0);
    check("rst_stall", 32'(bus.stall_o), 32'h0);
    check("rst_ready", 32'(bus.lsu_ready_o), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_ni = 1'b1;
  endtask

  initial begin
    int first_stall, w3, w4, acc, stalls;
    logic [4:0] lrd;

    bus.rs1_i = 5'd0;
    bus.rs2_i = 5'd0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    vecs[0] = '{1, 5'd5,  32'h12345678, 0, 5'd0, 32'h0,        1, 5'd5,  32'h12345678, 0, 5'd0, 32'h0};
    vecs[1] = '{1, 5'd0,  32'hFFFFFFFF, 0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 32'h0};
    vecs[2] = '{0, 5'd0,  32'h0,        1, 5'd0, 32'h55555555, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0};
    vecs[3] = '{0, 5'd0,  32'h0,        1, 5'd3, 32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 5'd3, 32'hDEADBEEF};
    vecs[4] = '{1, 5'd31, 32'h00000001, 1, 5'd7, 32'hCAFEF00D, 1, 5'd31, 32'h00000001, 1, 5'd7, 32'hCAFEF00D};
    vecs[5] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 32'h0};

    do_reset();
    foreach (vecs[k]) begin
      do_cycle(vecs[k].av, vecs[k].ard, vecs[k].awd, vecs[k].lv, vecs[k].lrd, vecs[k].lwd, 0, 0);
      check($sformatf("vec%0d_wr1", k), 32'(bus.regwrite_o), 32'(vecs[k].wr1));
      if (vecs[k].wr1) begin
        check($sformatf("vec%0d_rd1", k), 32'(bus.rd_o), 32'(vecs[k].rd1));
        check($sformatf("vec%0d_wd1", k), bus.wd_o, vecs[k].wd1);
      end
      idle(1);
      check($sformatf("vec%0d_wr2", k), 32'(bus.regwrite_o), 32'(vecs[k].wr2));
      if (vecs[k].wr2) begin
        check($sformatf("vec%0d_rd2", k), 32'(bus.rd_o), 32'(vecs[k].rd2));
        check($sformatf("vec%0d_wd2", k), bus.wd_o, vecs[k].wd2);
      end
      idle(1);
    end

    // Loads to x0 never occupy the buffer.
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 0, 0, 1, 5'd0, 32'hABCD0000 + 32'(i), 0, 0);
      check("x0_load_ready", 32'(s_ready), 32'h1);
    end
    idle(2);
    check("x0_load_nowrite", 32'(bus.regwrite_o), 32'h0);

    // Two loads under continuous ALU traffic: backpressure, starve drains, order.
    do_reset();
    first_stall = -1; w3 = -1; w4 = -1; acc = 0; stalls = 0;
    for (int i = 0; i < 12; i++) begin
      lrd = (i == 0) ? 5'd3 : (i == 1) ? 5'd4 : 5'd5;
      do_cycle(!m_drain, 5'(10 + i), 32'h100 + 32'(i), (i < 5), lrd, 32'hB0000000 + 32'(lrd), 0, 0);
      if (i < 5 && s_ready) acc++;
      if (bus.stall_o) begin
        stalls++;
        if (first_stall < 0) first_stall = i;
      end
      if (bus.regwrite_o && bus.rd_o == 5'd3 && w3 < 0) w3 = i;
      if (bus.regwrite_o && bus.rd_o == 5'd4 && w4 < 0) w4 = i;
    end
    check("starve_accepts", 32'(acc), 32'd2);
    check("starve_first_stall", 32'(first_stall), 32'd4);
    check("starve_stall_pulses", 32'(stalls), 32'd2);
    check("starve_rd3_cycle", 32'(w3), 32'd5);
    check("starve_rd4_cycle", 32'(w4), 32'd10);

    // Scoreboard: issue then retire a load to x7.
    do_reset();
    do_cycle(0, 0, 0, 0, 0, 0, 1, 5'd7);
    check("busy7_set", 32'(bus.busy_o[7]), 32'h1);
    idle(2);
    do_cycle(0, 0, 0, 1, 5'd7, 32'h77777777, 0, 0);
    check("busy7_held", 32'(bus.busy_o[7]), 32'h1);
    idle(1);
    check("busy7_wr", 32'(bus.regwrite_o), 32'h1);
    check("busy7_rd", 32'(bus.rd_o), 32'd7);
    check("busy7_clear", 32'(bus.busy_o[7]), 32'h0);

    // Simultaneous set and clear keeps the bit; x0 never marked.
    do_cycle(1, 5'd9, 32'h99999999, 0, 0, 0, 1, 5'd9);
    check("busy9_rd", 32'(bus.rd_o), 32'd9);
    check("busy9_kept", 32'(bus.busy_o[9]), 32'h1);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 5'd0);
    check("busy0_zero", 32'(bus.busy_o[0]), 32'h0);

    // Bypass compare.
    bus.rs1_i = 5'd5;
    bus.rs2_i = 5'd6;
    do_cycle(1, 5'd5, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
    check("byp_a_hit", 32'(bus.fwd_a_hit_o), 32'(BYP));
    check("byp_a_data", bus.fwd_a_o, BYP ? 32'hA5A5A5A5 : 32'h0);
    check("byp_b_hit", 32'(bus.fwd_b_hit_o), 32'h0);
    bus.rs1_i = 5'd0;
    bus.rs2_i = 5'd0;

    // Reset in the middle of buffered traffic discards everything.
    do_reset();
    do_cycle(1, 5'd10, 32'h10, 1, 5'd3, 32'h33, 1, 5'd12);
    do_cycle(1, 5'd11, 32'h11, 1, 5'd4, 32'h44, 0, 0);
    do_reset();
    idle(4);
    check("midrst_quiet", 32'(bus.regwrite_o), 32'h0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        av, lv, iss;
      logic [4:0]  ard, ld, ird;
      av  = m_drain ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 7);
      ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lv  = $urandom_range(0, 1) == 1;
      ld  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      iss = $urandom_range(0, 3) == 0;
      ird = 5'($urandom_range(0, 31));
      bus.rs1_i = 5'($urandom_range(0, 31));
      bus.rs2_i = 5'($urandom_range(0, 31));
      do_cycle(av, ard, $urandom, lv, ld, $urandom, iss, ird);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
